// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types for the EX issue slice: ALU op encoding, pipeline register words,
// operand forwarding select and register-file constants.
package ex_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  reg_wr_addr;
    logic        reg_wr_en;
    logic [31:0] inst_imm_sgn;
  } ID_EX;

  typedef struct packed {
    logic        alu_result_ready;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] alu_result;
  } EX_WB;

  typedef enum logic {
    FWD_NONE = 1'b0,
    FWD_EX   = 1'b1
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue and
// cleared at the WB write; x0 never pends. A same-edge set and clear leaves the bit set.
module ex_scoreboard
  import ex_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_en_i,
  input  logic [4:0] set_rd_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  logic [31:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
    if (set_en_i) pending_d[set_rd_i] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign rs1_busy_o = pending_q[rs1_i];
  assign rs2_busy_o = pending_q[rs2_i];

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue stage between decode and the ALU: captures operands into ID_EX and resolves RAW hazards.
// EX_ISSUE_FORWARD_EN defined: EX forward + capture bypass, never stalls; undefined: scoreboard stalls.
module ex_issue_ctrl
  import ex_issue_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  alu_op_t                dec_alu_op,
  input  logic [4:0]             dec_rs1,
  input  logic [4:0]             dec_rs2,
  input  logic [4:0]             dec_rd,
  input  logic                   dec_uses_rs2,
  input  logic                   dec_wr_en,
  input  logic [31:0]            dec_imm,
  input  logic                   flush,
  output logic [4:0]             rf_rs1_addr,
  output logic [4:0]             rf_rs2_addr,
  input  logic [31:0]            rf_rs1_data,
  input  logic [31:0]            rf_rs2_data,
  input  EX_WB                   ex_wb_reg,
  output ID_EX                   id_ex_reg,
  output logic [31:0]            alu_reg_input_a,
  output logic [31:0]            alu_reg_input_b,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  ID_EX                   id_ex_q, id_ex_d;
  logic [31:0]            opa_q, opa_d, opb_q, opb_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [31:0]            rs1_val, rs2_val;
  logic                   hazard, xfer, wb_wr;

  assign rf_rs1_addr = dec_rs1;
  assign rf_rs2_addr = dec_rs2;
  assign wb_wr = ex_wb_reg.alu_result_ready && ex_wb_reg.reg_wr_en &&
                 (ex_wb_reg.reg_wr_addr != REG_ZERO);

`ifdef EX_ISSUE_FORWARD_EN
  fwd_sel_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign hazard = 1'b0;

  // A match against the instruction now in EX is resolved next cycle from ex_wb_reg.
  always_comb begin
    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    if (xfer && id_ex_q.reg_wr_en && (id_ex_q.reg_wr_addr != REG_ZERO)) begin
      if (dec_rs1 == id_ex_q.reg_wr_addr) fwd_a_d = FWD_EX;
      if (dec_uses_rs2 && (dec_rs2 == id_ex_q.reg_wr_addr)) fwd_b_d = FWD_EX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign alu_reg_input_a = (fwd_a_q == FWD_EX) ? ex_wb_reg.alu_result : opa_q;
  assign alu_reg_input_b = (fwd_b_q == FWD_EX) ? ex_wb_reg.alu_result : opb_q;
`else
  logic rs1_busy, rs2_busy;
  logic unused_alu_result;

  ex_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en_i   (xfer && dec_wr_en && (dec_rd != REG_ZERO)),
    .set_rd_i   (dec_rd),
    .clr_en_i   (wb_wr),
    .clr_rd_i   (ex_wb_reg.reg_wr_addr),
    .rs1_i      (dec_rs1),
    .rs2_i      (dec_rs2),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  assign hazard = dec_valid && (rs1_busy || (dec_uses_rs2 && rs2_busy));
  assign unused_alu_result = ^ex_wb_reg.alu_result;
  assign alu_reg_input_a = opa_q;
  assign alu_reg_input_b = opb_q;
`endif

  assign dec_ready = !flush && !hazard;
  assign xfer      = dec_valid && dec_ready;

  // RF data is the pre-write value, so a result being written this cycle is bypassed in.
  always_comb begin
    rs1_val = (dec_rs1 == REG_ZERO) ? 32'd0 : rf_rs1_data;
    rs2_val = (dec_rs2 == REG_ZERO) ? 32'd0 : rf_rs2_data;
`ifdef EX_ISSUE_FORWARD_EN
    if (wb_wr && (ex_wb_reg.reg_wr_addr == dec_rs1)) rs1_val = ex_wb_reg.alu_result;
    if (wb_wr && (ex_wb_reg.reg_wr_addr == dec_rs2)) rs2_val = ex_wb_reg.alu_result;
`endif
  end

  always_comb begin
    id_ex_d        = '0;
    id_ex_d.alu_op = ALU_NONE;
    opa_d          = 32'd0;
    opb_d          = 32'd0;
    if (xfer) begin
      id_ex_d.alu_op       = dec_alu_op;
      id_ex_d.reg_wr_addr  = dec_rd;
      id_ex_d.reg_wr_en    = dec_wr_en;
      id_ex_d.inst_imm_sgn = dec_imm;
      opa_d                = rs1_val;
      opb_d                = dec_uses_rs2 ? rs2_val : dec_imm;
    end
    stall_d = stall_q;
    if (dec_valid && !dec_ready && !flush && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_q        <= '0;
      id_ex_q.alu_op <= ALU_NONE;
      opa_q          <= '0;
      opb_q          <= '0;
      stall_q        <= '0;
    end else begin
      id_ex_q <= id_ex_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      stall_q <= stall_d;
    end
  end

  assign id_ex_reg    = id_ex_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl with a behavioural ALU output register and register file.
module tb_ex_issue_ctrl;
  import ex_issue_ctrl_pkg::*;

  localparam int SCW = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           dec_valid = 1'b0;
  logic           dec_ready;
  alu_op_t        dec_alu_op = ALU_NONE;
  logic [4:0]     dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic           dec_uses_rs2 = 1'b0, dec_wr_en = 1'b0;
  logic [31:0]    dec_imm = '0;
  logic           flush = 1'b0;
  logic [4:0]     rf_rs1_addr, rf_rs2_addr;
  logic [31:0]    rf_rs1_data, rf_rs2_data;
  EX_WB           ex_wb_reg;
  ID_EX           id_ex_reg;
  logic [31:0]    alu_reg_input_a, alu_reg_input_b;
  logic [SCW-1:0] stall_cycles;

  logic [31:0]    rf [32];
  logic [31:0]    x0_val = 32'd0;
  int             passed = 0;
  int             total = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_alu_op(dec_alu_op), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_uses_rs2(dec_uses_rs2), .dec_wr_en(dec_wr_en), .dec_imm(dec_imm), .flush(flush),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_wb_reg(ex_wb_reg), .id_ex_reg(id_ex_reg),
    .alu_reg_input_a(alu_reg_input_a), .alu_reg_input_b(alu_reg_input_b),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [31:0] alu_model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // x0 deliberately returns x0_val so the DUT's own zeroing of x0 is observable.
  assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? x0_val : rf[rf_rs1_addr];
  assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? x0_val : rf[rf_rs2_addr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_wb_reg <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (ex_wb_reg.alu_result_ready && ex_wb_reg.reg_wr_en && ex_wb_reg.reg_wr_addr != 5'd0)
        rf[ex_wb_reg.reg_wr_addr] <= ex_wb_reg.alu_result;
      ex_wb_reg.alu_result_ready <= (id_ex_reg.alu_op != ALU_NONE);
      ex_wb_reg.reg_wr_en        <= id_ex_reg.reg_wr_en;
      ex_wb_reg.reg_wr_addr      <= id_ex_reg.reg_wr_addr;
      ex_wb_reg.alu_result       <= alu_model(id_ex_reg.alu_op, alu_reg_input_a, alu_reg_input_b);
    end
  end

  task automatic offer(input alu_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use2, input logic [31:0] imm);
    dec_valid = 1'b1; dec_alu_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_uses_rs2 = use2; dec_wr_en = 1'b1; dec_imm = imm;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_alu_op = ALU_NONE; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_uses_rs2 = 1'b0; dec_wr_en = 1'b0; dec_imm = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; flush = 1'b0; x0_val = 32'd0; idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); offer(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'd5);
    @(negedge clk); offer(ALU_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 32'd0);
    @(negedge clk); reset_n = 1'b0; idle(); #1;
    if (id_ex_reg.alu_op !== ALU_NONE) $display("FAIL rst_alu_op: got %0d want %0d", id_ex_reg.alu_op, ALU_NONE); else passed++; total++;
    if (id_ex_reg !== ID_EX'(0)) $display("FAIL rst_id_ex: got %h want 0", id_ex_reg); else passed++; total++;
    if (dec_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", dec_ready); else passed++; total++;
    if (stall_cycles !== '0) $display("FAIL rst_stall: got %0d want 0", stall_cycles); else passed++; total++;
    if (alu_reg_input_a !== 32'd0) $display("FAIL rst_opa: got %0d want 0", alu_reg_input_a); else passed++; total++;
    if (alu_reg_input_b !== 32'd0) $display("FAIL rst_opb: got %0d want 0", alu_reg_input_b); else passed++; total++;
    @(negedge clk); reset_n = 1'b1; offer(ALU_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 32'd0); #1;
    if (dec_ready !== 1'b1) $display("FAIL rst_sb_clear: got %0b want 1", dec_ready); else passed++; total++;
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); offer(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'd5);
    @(negedge clk); offer(ALU_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 32'd0); #1;
`ifdef EX_ISSUE_FORWARD_EN
    if (dec_ready !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", dec_ready); else passed++; total++;
    @(negedge clk); idle(); #1;
`else
    if (dec_ready !== 1'b0) $display("FAIL b2b_stall1: got %0b want 0", dec_ready); else passed++; total++;
    @(negedge clk); #1;
    if (dec_ready !== 1'b0) $display("FAIL b2b_stall2: got %0b want 0", dec_ready); else passed++; total++;
    if (id_ex_reg.alu_op !== ALU_NONE) $display("FAIL b2b_bubble1: got %0d want %0d", id_ex_reg.alu_op, ALU_NONE); else passed++; total++;
    @(negedge clk); #1;
    if (dec_ready !== 1'b1) $display("FAIL b2b_release: got %0b want 1", dec_ready); else passed++; total++;
    if (id_ex_reg.alu_op !== ALU_NONE) $display("FAIL b2b_bubble2: got %0d want %0d", id_ex_reg.alu_op, ALU_NONE); else passed++; total++;
    @(negedge clk); idle(); #1;
`endif
    if (id_ex_reg.alu_op !== ALU_ADD || id_ex_reg.reg_wr_addr !== 5'd2) $display("FAIL b2b_issue: got op %0d rd %0d want op %0d rd 2", id_ex_reg.alu_op, id_ex_reg.reg_wr_addr, ALU_ADD); else passed++; total++;
    if (alu_reg_input_a !== 32'd5) $display("FAIL b2b_opa: got %0d want 5", alu_reg_input_a); else passed++; total++;
    if (alu_reg_input_b !== 32'd5) $display("FAIL b2b_opb: got %0d want 5", alu_reg_input_b); else passed++; total++;
`ifdef EX_ISSUE_FORWARD_EN
    if (stall_cycles !== 3'd0) $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cycles); else passed++; total++;
`else
    if (stall_cycles !== 3'd2) $display("FAIL b2b_stall_cnt: got %0d want 2", stall_cycles); else passed++; total++;
`endif
    @(negedge clk); #1;
    if (ex_wb_reg.alu_result !== 32'd10) $display("FAIL b2b_result: got %0d want 10", ex_wb_reg.alu_result); else passed++; total++;
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk); offer(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'd7);
    @(negedge clk); idle();
    @(negedge clk); offer(ALU_ADD, 5'd3, 5'd1, 5'd0, 1'b1, 32'd0); #1;
`ifdef EX_ISSUE_FORWARD_EN
    if (dec_ready !== 1'b1) $display("FAIL byp_ready: got %0b want 1", dec_ready); else passed++; total++;
`else
    if (dec_ready !== 1'b0) $display("FAIL byp_stall: got %0b want 0", dec_ready); else passed++; total++;
    @(negedge clk); #1;
    if (dec_ready !== 1'b1) $display("FAIL byp_release: got %0b want 1", dec_ready); else passed++; total++;
`endif
    @(negedge clk); idle(); #1;
    if (alu_reg_input_a !== 32'd7) $display("FAIL byp_opa: got %0d want 7", alu_reg_input_a); else passed++; total++;
    if (alu_reg_input_b !== 32'd0) $display("FAIL byp_opb: got %0d want 0", alu_reg_input_b); else passed++; total++;
`ifdef EX_ISSUE_FORWARD_EN
    if (stall_cycles !== 3'd0) $display("FAIL byp_stall_cnt: got %0d want 0", stall_cycles); else passed++; total++;
`else
    if (stall_cycles !== 3'd1) $display("FAIL byp_stall_cnt: got %0d want 1", stall_cycles); else passed++; total++;
`endif
    @(negedge clk); #1;
    if (ex_wb_reg.alu_result !== 32'd7) $display("FAIL byp_result: got %0d want 7", ex_wb_reg.alu_result); else passed++; total++;
  endtask

  task automatic test_x0();
    do_reset();
    x0_val = 32'hDEAD_BEEF;
    @(negedge clk); offer(ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 32'd9);
    @(negedge clk); offer(ALU_ADD, 5'd4, 5'd0, 5'd0, 1'b1, 32'd0); #1;
    if (dec_ready !== 1'b1) $display("FAIL x0_ready: got %0b want 1", dec_ready); else passed++; total++;
    @(negedge clk); idle(); #1;
    if (id_ex_reg.reg_wr_addr !== 5'd4) $display("FAIL x0_issue: got rd %0d want 4", id_ex_reg.reg_wr_addr); else passed++; total++;
    if (alu_reg_input_a !== 32'd0) $display("FAIL x0_opa: got %h want 0", alu_reg_input_a); else passed++; total++;
    if (alu_reg_input_b !== 32'd0) $display("FAIL x0_opb: got %h want 0", alu_reg_input_b); else passed++; total++;
    @(negedge clk); #1;
    if (ex_wb_reg.alu_result !== 32'd0) $display("FAIL x0_result: got %h want 0", ex_wb_reg.alu_result); else passed++; total++;
    if (stall_cycles !== 3'd0) $display("FAIL x0_stall_cnt: got %0d want 0", stall_cycles); else passed++; total++;
    x0_val = 32'd0;
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); offer(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'd5);
    @(negedge clk); offer(ALU_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 32'd0);
    @(negedge clk); flush = 1'b1; #1;
    if (dec_ready !== 1'b0) $display("FAIL fl_ready: got %0b want 0", dec_ready); else passed++; total++;
    @(negedge clk); flush = 1'b0; offer(ALU_ADD, 5'd5, 5'd1, 5'd1, 1'b1, 32'd0); #1;
    if (id_ex_reg.alu_op !== ALU_NONE) $display("FAIL fl_bubble: got %0d want %0d", id_ex_reg.alu_op, ALU_NONE); else passed++; total++;
`ifdef EX_ISSUE_FORWARD_EN
    if (stall_cycles !== 3'd0) $display("FAIL fl_stall_cnt: got %0d want 0", stall_cycles); else passed++; total++;
`else
    if (stall_cycles !== 3'd1) $display("FAIL fl_stall_cnt: got %0d want 1", stall_cycles); else passed++; total++;
`endif
    if (dec_ready !== 1'b1) $display("FAIL fl_pending_clr: got %0b want 1", dec_ready); else passed++; total++;
    @(negedge clk); idle(); #1;
    if (alu_reg_input_a !== 32'd5) $display("FAIL fl_opa: got %0d want 5", alu_reg_input_a); else passed++; total++;
  endtask

  task automatic test_stall_sat();
    logic [SCW-1:0] exp_mid, exp_end;
`ifdef EX_ISSUE_FORWARD_EN
    exp_mid = 3'd0; exp_end = 3'd0;
`else
    exp_mid = 3'd6; exp_end = 3'd7;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); offer(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'(i + 1));
      @(negedge clk); offer(ALU_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      if (i == 2) begin
        #1;
        if (stall_cycles !== exp_mid) $display("FAIL sat_mid: got %0d want %0d", stall_cycles, exp_mid); else passed++; total++;
      end
    end
    @(negedge clk); idle(); #1;
    if (stall_cycles !== exp_end) $display("FAIL sat_end: got %0d want %0d", stall_cycles, exp_end); else passed++; total++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bypass();
    test_x0();
    test_flush();
    test_stall_sat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ex_issue_ctrl.md
# ex_issue_ctrl

Issue controller between decode and `alu_stage`. Accepts one decoded ALU instruction per cycle over a valid/ready handshake, reads the register file, and detects RAW hazards against in-flight results. It resolves each hazard by operand forwarding or by stalling, then drives the registered `ID_EX` word and the two ALU operand buses. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode presents an instruction.
- `dec_ready`  out  1  controller accepts the instruction this cycle.
- `dec_alu_op`  in  `alu_op_t`  operation.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  register specifiers.
- `dec_uses_rs2`  in  1  rs2 is a source operand (reg-reg ops).
- `dec_wr_en`  in  1  instruction writes `dec_rd`.
- `dec_imm`  in  32  sign-extended immediate.
- `flush`  in  1  synchronous kill of the instruction being offered.
- `rf_rs1_addr`, `rf_rs2_addr`  out  5 each  register-file read addresses (combinational from `dec_rs1`/`dec_rs2`).
- `rf_rs1_data`, `rf_rs2_data`  in  32 each  register-file read data (pre-write value in a write cycle).
- `ex_wb_reg`  in  `EX_WB`  ALU output register; also the register-file write port (`alu_result_ready`, `reg_wr_en`, `reg_wr_addr`, `alu_result`).
- `id_ex_reg`  out  `ID_EX`  registered issue word.
- `alu_reg_input_a`, `alu_reg_input_b`  out  32 each  ALU operands.
- `stall_cycles`  out  `STALL_CNT_W`  saturating count of stall cycles.

## Operation
- **Transfer:** an instruction is transferred when `dec_valid && dec_ready` at a clock edge.
  - `id_ex_reg` loads `alu_op`, `reg_wr_addr`, `reg_wr_en`, and `inst_imm_sgn`.
  - Captured operands: `opA` = rs1 value; `opB` = rs2 value if `dec_uses_rs2`, else `dec_imm`.
- **Bubble:** if there is no transfer, `id_ex_reg` loads a bubble: `alu_op=ALU_NONE`, `reg_wr_en=0`, other fields 0.
- **`flush`:** forces `dec_ready=0` and a bubble. The offered instruction is dropped, and decode withdraws it.
- **"WB write":** `ex_wb_reg.alu_result_ready && ex_wb_reg.reg_wr_en && ex_wb_reg.reg_wr_addr != 0`.
- **Capture bypass:** at capture, a source matching the WB write address takes `ex_wb_reg.alu_result` instead of RF data.
- **EX forward:** per operand, a `fwd_sel` flag is registered at capture. It is set when the source equals the `reg_wr_addr` of the instruction currently in `id_ex_reg` with `reg_wr_en=1` and nonzero address.
  - While `fwd_sel` is set, `alu_reg_input_x = ex_wb_reg.alu_result`; otherwise it is the captured operand.
  - This path is combinational.
  - EX forward has priority over capture bypass.
- **x0:** source x0 always reads 0. It is never forwarded, never pending, and never stalls.
- **Hazard check:** rs2 is checked only when `dec_uses_rs2`.
- **Stall counter:** `stall_cycles` increments each cycle with `dec_valid && !dec_ready && !flush`. It saturates at all-ones.

## Timing
- **Reset values:**
  - `id_ex_reg` is all-zero with `alu_op=ALU_NONE`.
  - Operand registers and `fwd_sel` are 0, so `alu_reg_input_a/b` read 0.
  - `stall_cycles` is 0.
  - Scoreboard is clear; `dec_ready=1`.
- **Issue pipeline:** issue at edge E0 → EX cycle [E0,E1) → `ex_wb_reg` valid in [E1,E2) → RF written at E2.
- **With forwarding:** dependents at distance 1 (via EX forward) and distance 2 (via capture bypass) issue with no stall. `dec_ready` depends only on `flush`.
- **Without forwarding:** both forwarding paths are removed.
  - A dependent stalls until its source's pending bit clears at E2, and issues at E3 earliest (2 bubbles).
  - `dec_ready` may depend combinationally on `dec_valid`.
  - Decode holds its fields stable while `dec_valid && !dec_ready`.
- **Scoreboard, same-cycle set and clear:** if a register's pending bit is set and cleared at the same edge, set wins.
- **Reset mid-stall:** drops the held instruction and clears the scoreboard.

## Configuration
- **`EX_ISSUE_FORWARD_EN` defined:**
  - EX-forward mux and capture bypass are present.
  - No scoreboard; no hazard stalls.
- **Undefined:**
  - The ALU operand outputs come only from the captured registers.
  - The scoreboard is compiled in and stalls RAW hazards as above.
  - Outputs are functionally identical apart from the added bubbles.

## Structure
- **Shared package:**
  - Existing `alu_op_t`, `ID_EX`, and `EX_WB` stay in the shared headers.
  - Add `fwd_sel_t {FWD_NONE, FWD_EX}` and constant `REG_ZERO = 5'd0`.
- **Sub-module `ex_scoreboard`:**
  - 32-entry pending vector, with entry 0 hardwired to 0.
  - Set port from issue (`rd`, `wr_en`); clear port from the WB write.
  - Two combinational busy lookups for rs1 and rs2.
  - Instantiated only without `EX_ISSUE_FORWARD_EN`.

## Test plan
- Reset asserted mid-stream → `id_ex_reg.alu_op=ALU_NONE`, `dec_ready=1`, `stall_cycles=0`, operands 0.
- Forwarding on, ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back → in ADD's EX cycle, `alu_reg_input_a=b=5`; next cycle `alu_result=10`; no stall.
- Forwarding on, ADDI x1,x0,7, one idle cycle, then ADD x3,x1,x0 → capture bypass gives `opA=7`, result 7.
- Forwarding off, the same sequence as the back-to-back ADDI/ADD test → `dec_ready` low 2 cycles, 2 bubbles, `stall_cycles=2`, then `alu_reg_input_a=5`.
- Either configuration, ADDI x0,x0,9 then ADD x4,x0,x0 → operands 0, result 0, no stall.
- Forwarding off, `flush` asserted during a stall → bubble issued; `stall_cycles` does not increment for the flush cycle; x1 pending bit still clears at its WB write.
